scope_frame_controller: RTL and testbench

SCOPE_FRAME_CONTROLLER -- requirements
Module: scope_frame_controller

---
 rtl/scope_frame_controller.sv | 90 +++++++++
 tb/tb_scope_frame_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scope_frame_controller.sv
// scope_frame_controller: single-trigger scope capture into a sample RAM during vertical blanking, trace readout during display
//   clk, rst                      pixel clock, async active-high reset
//   counter_x/counter_y/in_display timing generator position and active-area flag
//   adc_valid/adc_ready/adc_data  ADC sample handshake
//   trig_level, force_trig        rising-edge trigger threshold, forced trigger
//   ram_addr/ram_we/ram_wdata/ram_rdata  sample RAM port (1-cycle read latency)
//   pixel_on                      trace pixel lit, 2 cycles after the counters
//   capture_ok                    last capture attempt stored all 640 samples
module scope_frame_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] counter_x,
  input  logic [8:0] counter_y,
  input  logic       in_display,
  input  logic       adc_valid,
  input  logic [7:0] adc_data,
  output logic       adc_ready,
  input  logic [7:0] trig_level,
  input  logic       force_trig,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       pixel_on,
  output logic       capture_ok
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;
  state_t     state;
  logic [9:0] wr_ptr;
  logic [7:0] prev_sample;
  logic [8:0] y_d1;
  logic       disp_d1;
  logic       blank, frame_end, frame_arm, take, trig;
  assign blank     = counter_y >= 9'd480;
  assign frame_end = counter_y == 9'd0 && counter_x == 10'd0;
  assign frame_arm = counter_y == 9'd480 && counter_x == 10'd0;
  // ready only during blanking, so a sample can never land on the frame-end cycle
  assign adc_ready = blank && (state == ARMED || state == CAPTURE);
  assign take      = adc_valid && adc_ready;
  assign trig      = state == ARMED && (force_trig || (prev_sample < trig_level && adc_data >= trig_level));
  assign ram_we    = take && (trig || state == CAPTURE);
  assign ram_addr  = !blank ? counter_x : state == CAPTURE ? wr_ptr : 10'd0;
  assign ram_wdata = adc_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      prev_sample <= 8'hFF;
      pixel_on    <= 1'b0;
      capture_ok  <= 1'b0;
      y_d1        <= '0;
      disp_d1     <= 1'b0;
    end else begin
      y_d1     <= counter_y;
      disp_d1  <= in_display;
      pixel_on <= disp_d1 && (y_d1[8:1] == 8'd255 - ram_rdata);
      case (state)
        IDLE:
          if (frame_arm) begin
            state       <= ARMED;
            prev_sample <= 8'hFF;
          end
        ARMED:
          if (frame_end) state <= IDLE;
          else if (take) begin
            prev_sample <= adc_data;
            if (trig) begin
              state  <= CAPTURE;
              wr_ptr <= 10'd1;
            end
          end
        CAPTURE:
          if (frame_end) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            capture_ok <= 1'b0;
          end else if (take) begin
            if (wr_ptr == 10'd639) begin
              state      <= HOLD;
              capture_ok <= 1'b1;
            end else wr_ptr <= wr_ptr + 10'd1;
          end
        HOLD:
          if (frame_end) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_scope_frame_controller.sv
// tb_scope_frame_controller: directed stimulus with a behavioural capture/trace model and per-cycle compare
module tb_scope_frame_controller;
  logic       clk = 0, rst = 1;
  logic [9:0] counter_x = 0;
  logic [8:0] counter_y = 0;
  logic       in_display = 0, adc_valid = 0, force_trig = 0;
  logic [7:0] adc_data = 0, trig_level = 8'd100;
  logic       adc_ready, ram_we, pixel_on, capture_ok;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       preload = 0;
  logic [7:0] ram [1024];

  scope_frame_controller dut (
    .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
    .in_display(in_display), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_ready(adc_ready), .trig_level(trig_level), .force_trig(force_trig),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel_on(pixel_on), .capture_ok(capture_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 1024; i++) ram[i] <= 8'h80;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // model: an attempt is "live" from arming until it fills or the frame ends;
  // m_n counts samples stored in the current attempt (0 = still waiting for trigger)
  logic       m_live, m_done, m_ok, pend, e_pix;
  logic [9:0] m_n;
  logic [7:0] m_prev;
  logic [7:0] exp_mem [1024];
  logic       e_ready, e_acc, e_hit, e_we, bend;
  logic [9:0] e_addr;

  always_comb begin
    bend    = counter_y == 0 && counter_x == 0;
    e_ready = m_live && counter_y >= 480;
    e_acc   = e_ready && adc_valid;
    e_hit   = m_n == 0 && (force_trig || (m_prev < trig_level && adc_data >= trig_level));
    e_we    = e_acc && (m_n > 0 || e_hit);
    e_addr  = counter_y < 480 ? counter_x : (m_live ? m_n : 10'd0);
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_live <= 0; m_done <= 0; m_ok <= 0; m_n <= 0; m_prev <= 8'hFF; pend <= 0; e_pix <= 0;
    end else begin
      if (preload) for (int i = 0; i < 1024; i++) exp_mem[i] <= 8'h80;
      pend  <= in_display && (int'(counter_y) / 2 + int'(exp_mem[counter_x]) == 255);
      e_pix <= pend;
      if (bend) begin
        m_live <= 0; m_done <= 0;
        if (m_live && m_n > 0) m_ok <= 0;
      end else if (!m_live && !m_done && counter_y == 480 && counter_x == 0) begin
        m_live <= 1; m_n <= 0; m_prev <= 8'hFF;
      end else if (e_acc) begin
        if (m_n == 0) m_prev <= adc_data;
        if (e_we) begin
          exp_mem[e_addr] <= adc_data;
          m_n <= m_n + 10'd1;
          if (m_n == 10'd639) begin m_live <= 0; m_done <= 1; m_ok <= 1; end
        end
      end
    end

  int n_chk = 0, n_fail = 0, we_cnt = 0, pix_cnt = 0, first_addr = -1;
  bit en = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) if (en) begin
    chk("adc_ready", adc_ready, e_ready);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, adc_data);
    chk("pixel_on", pixel_on, e_pix);
    chk("capture_ok", capture_ok, m_ok);
    if (ram_we && we_cnt == 0) first_addr = ram_addr;
    if (ram_we) we_cnt++;
    if (pixel_on) pix_cnt++;
  end

  int  vmode = 0, tick = 0;
  bit  ramp = 0;
  logic [7:0] rv = 0;

  task automatic cyc(input int x, input int y);
    @(posedge clk); #1;
    counter_x  = 10'(x);
    counter_y  = 9'(y);
    in_display = y < 480 && x < 640;
    adc_valid  = vmode == 1 || (vmode == 2 && tick % 100 == 0);
    tick++;
    if (ramp) begin adc_data = rv; rv++; end
  endtask

  task automatic line(input int y);
    for (int x = 0; x < 800; x++) cyc(x, y);
  endtask

  initial begin
    cyc(0, 0); cyc(0, 0);
    en = 1;
    @(negedge clk);
    chk("rst_ready", adc_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_pix", pixel_on, 0);
    chk("rst_ok", capture_ok, 0);
    cyc(1, 0); rst = 0;
    preload = 1; cyc(1, 1); preload = 0;
    // trace readout: 0x80 lights lines 254 and 255 only
    pix_cnt = 0;
    for (int y = 252; y < 258; y++) line(y);
    cyc(0, 258); cyc(1, 258); cyc(2, 258);
    chk("pix_count", pix_cnt, 1280);
    // ramp capture
    we_cnt = 0; ramp = 1; rv = 0; vmode = 1;
    line(480); line(481);
    ramp = 0;
    chk("ramp_ok", capture_ok, 1);
    chk("ramp_writes", we_cnt, 640);
    chk("ram0", ram[0], 100);
    chk("ram1", ram[1], 101);
    chk("ram639", ram[639], 227);
    chk("ram640", ram[640], 128);
    cyc(0, 0); cyc(1, 0);
    // constant below-threshold input never triggers
    adc_data = 50; we_cnt = 0;
    line(480); line(481);
    cyc(0, 0); cyc(1, 0);
    chk("notrig_writes", we_cnt, 0);
    chk("notrig_ok", capture_ok, 1);
    cyc(5, 481);
    @(negedge clk);
    chk("notrig_idle", adc_ready, 0);
    cyc(0, 1);
    // sparse forced samples: capture aborted by frame end
    force_trig = 1; adc_data = 7; vmode = 2; tick = 0; we_cnt = 0;
    line(480);
    cyc(0, 0);
    line(1);
    chk("abort_writes", we_cnt, 7);
    chk("abort_ok", capture_ok, 0);
    // reset in the middle of a capture
    force_trig = 0; vmode = 1; ramp = 1; rv = 0;
    for (int x = 0; x < 800 && m_n != 10'd300; x++) cyc(x, 480);
    chk("reach300", int'(m_n), 300);
    chk("pre_rst_we", ram_we, 1);
    #1 rst = 1;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_ready", adc_ready, 0);
    chk("arst_pix", pixel_on, 0);
    chk("arst_ok", capture_ok, 0);
    cyc(401, 480); rst = 0;
    ramp = 0; we_cnt = 0;
    line(481);
    chk("post_rst_idle", we_cnt, 0);
    force_trig = 1; adc_data = 33; first_addr = -1;
    line(480);
    chk("restart_addr", first_addr, 0);
    chk("restart_ram0", ram[0], 33);
    chk("restart_ok", capture_ok, 1);
    cyc(0, 0); cyc(1, 0);
    // trigger sample on the frame-end cycle is dropped
    vmode = 0;
    cyc(0, 480); cyc(1, 480); cyc(2, 480);
    vmode = 1;
    cyc(0, 0);
    @(negedge clk);
    chk("fe_we", ram_we, 0);
    chk("fe_ready", adc_ready, 0);
    cyc(3, 481);
    @(negedge clk);
    chk("fe_idle", adc_ready, 0);
    cyc(4, 481);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
